// File: rtl/rff_ser_pkg.sv
// rff_ser_pkg: shared state type, counter-width helper and reset values for rff_serializer.
package rff_ser_pkg;

    typedef enum logic {IDLE, SHIFT} state_t;

    localparam state_t RST_STATE = IDLE;
    localparam logic   RST_BIT   = 1'b0;

    function automatic int CNT_W(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/rff_ser_shreg.sv
// rff_ser_shreg: WIDTH-bit shift register with load, shift enable and MSB/LSB serial tap.
module rff_ser_shreg
    import rff_ser_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] load_data,
    output logic             tap
);

    logic [WIDTH-1:0] sreg;

    // load wins over shift so a back-to-back reload replaces the final shift
    always_ff @(posedge clk) begin
        if (reset)
            sreg <= {WIDTH{RST_BIT}};
        else if (load)
            sreg <= load_data;
        else if (shift)
            sreg <= MSB_FIRST ? {sreg[WIDTH-2:0], RST_BIT} : {RST_BIT, sreg[WIDTH-1:1]};
    end

    assign tap = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];

endmodule

// File: rtl/rff_serializer.sv
// rff_serializer: valid/ready word intake, shifted out one bit per unheld clock with valid and last markers.
module rff_serializer
    import rff_ser_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             hold,
    output logic             d_out,
    output logic             d_valid,
    output logic             d_last,
    output logic             busy
);

    localparam int            CW   = CNT_W(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          shifting, take, tap;

    rff_ser_shreg #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_shreg (
        .clk       (clk),
        .reset     (reset),
        .load      (take),
        .shift     (shifting),
        .load_data (in_data),
        .tap       (tap)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RST_STATE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // counter returns to 0 on exit so it never runs past the last index
    always_comb begin
        shifting  = (state == SHIFT) && !hold;
        d_last    = shifting && (cnt == LAST);
        in_ready  = !reset && ((state == IDLE) || d_last);
        take      = in_valid && in_ready;
        d_valid   = shifting;
        d_out     = tap;
        busy      = (state == SHIFT);
        state_nxt = take ? SHIFT : (d_last ? IDLE : state);
        cnt_nxt   = (take || d_last) ? '0 : (shifting ? cnt + 1'b1 : cnt);
    end

endmodule

// File: tb/tb_rff_serializer.sv
// tb_rff_serializer: directed checks of an MSB-first and an LSB-first serializer driven in parallel.
module tb_rff_serializer;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic       hold;
    logic       in_ready_m, d_out_m, d_valid_m, d_last_m, busy_m;
    logic       in_ready_l, d_out_l, d_valid_l, d_last_l, busy_l;
    logic [9:0] obs, exp;
    int         vectors = 0;
    int         errors  = 0;

    always #5 clk = ~clk;

    rff_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_m),
        .hold(hold), .d_out(d_out_m), .d_valid(d_valid_m), .d_last(d_last_m), .busy(busy_m)
    );

    rff_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_l),
        .hold(hold), .d_out(d_out_l), .d_valid(d_valid_l), .d_last(d_last_l), .busy(busy_l)
    );

    // {d_out m/l, d_valid m/l, d_last m/l, busy m/l, in_ready m/l}
    assign obs = {d_out_m, d_out_l, d_valid_m, d_valid_l, d_last_m, d_last_l,
                  busy_m, busy_l, in_ready_m, in_ready_l};

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; hold = 1'b0; in_data = 8'h00;
        repeat (3) @(negedge clk);
        #1 vectors++;
        if (obs !== 10'b00_00_00_00_00) begin
            errors++; $display("FAIL reset_held obs=%b exp=%b", obs, 10'b0);
        end
        reset = 1'b0;
        #1 vectors++;
        if (obs !== 10'b00_00_00_00_11) begin
            errors++; $display("FAIL reset_release obs=%b exp=%b", obs, 10'b00_00_00_00_11);
        end
        @(negedge clk);
    endtask

    // bits in order: MSB dut shows w[7-k], LSB dut shows w[k]
    task automatic run_word(input logic [7:0] w, input string name);
        in_data = w; in_valid = 1'b1;
        #1 vectors++;
        if ({in_ready_m, in_ready_l} !== 2'b11) begin
            errors++; $display("FAIL %s_accept in_ready=%b exp=11", name, {in_ready_m, in_ready_l});
        end
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            #1 exp = {w[7-k], w[k], 2'b11, {2{k == 7}}, 2'b11, {2{k == 7}}};
            vectors++;
            if (obs !== exp) begin
                errors++; $display("FAIL %s_bit%0d obs=%b exp=%b", name, k, obs, exp);
            end
            @(negedge clk);
        end
        #1 vectors++;
        if (obs !== 10'b00_00_00_00_11) begin
            errors++; $display("FAIL %s_idle obs=%b exp=%b", name, obs, 10'b00_00_00_00_11);
        end
    endtask

    task automatic test_msb_lsb();
        run_word(8'hA5, "a5");
        @(negedge clk);
        run_word(8'h01, "01");
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        in_data = 8'hFF; in_valid = 1'b1;
        @(negedge clk);
        in_data = 8'h00;
        for (int c = 0; c < 16; c++) begin
            #1 exp = {{2{c < 8}}, 2'b11, {2{c == 7 || c == 15}}, 2'b11, {2{c == 7 || c == 15}}};
            vectors++;
            if (obs !== exp) begin
                errors++; $display("FAIL b2b_cycle%0d obs=%b exp=%b", c, obs, exp);
            end
            @(negedge clk);
            if (c == 7) in_valid = 1'b0;
        end
        #1 vectors++;
        if ({busy_m, busy_l} !== 2'b00) begin
            errors++; $display("FAIL b2b_done busy=%b exp=00", {busy_m, busy_l});
        end
        @(negedge clk);
    endtask

    task automatic test_hold();
        logic [7:0] w;
        int k, cycles;
        w = 8'hC3; in_data = w; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        cycles = 0;
        for (int c = 0; c < 11; c++) begin
            hold = (c >= 3 && c <= 5);
            k = (c < 3) ? c : (c < 6) ? 3 : c - 3;
            #1 exp = {w[7-k], w[k], {2{!hold}}, {2{c == 10}}, 2'b11, {2{c == 10}}};
            vectors++;
            if (obs !== exp) begin
                errors++; $display("FAIL hold_cycle%0d obs=%b exp=%b", c, obs, exp);
            end
            cycles++;
            @(negedge clk);
        end
        hold = 1'b0;
        #1 vectors++;
        if ({busy_m, busy_l, cycles} !== {2'b00, 32'd11}) begin
            errors++; $display("FAIL hold_len busy=%b cycles=%0d exp busy=00 cycles=11", {busy_m, busy_l}, cycles);
        end
        @(negedge clk);
    endtask

    task automatic test_hold_last();
        logic [7:0] w;
        w = 8'h3C; in_data = w; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(negedge clk);
        in_data = 8'h96; in_valid = 1'b1; hold = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1 exp = {w[0], w[7], 2'b00, 2'b00, 2'b11, 2'b00};
            vectors++;
            if (obs !== exp) begin
                errors++; $display("FAIL holdlast_cycle%0d obs=%b exp=%b", c, obs, exp);
            end
            @(negedge clk);
        end
        hold = 1'b0;
        #1 exp = {w[0], w[7], 2'b11, 2'b11, 2'b11, 2'b11};
        vectors++;
        if (obs !== exp) begin
            errors++; $display("FAIL holdlast_release obs=%b exp=%b", obs, exp);
        end
        @(negedge clk);
        in_valid = 1'b0;
        w = 8'h96;
        for (int k = 0; k < 8; k++) begin
            #1 exp = {w[7-k], w[k], 2'b11, {2{k == 7}}, 2'b11, {2{k == 7}}};
            vectors++;
            if (obs !== exp) begin
                errors++; $display("FAIL holdlast_next_bit%0d obs=%b exp=%b", k, obs, exp);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] w;
        w = 8'h5A; in_data = w; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1 exp = {w[7-k], w[k], 2'b11, 2'b00, 2'b11, 2'b00};
            vectors++;
            if (obs !== exp) begin
                errors++; $display("FAIL rstmid_bit%0d obs=%b exp=%b", k, obs, exp);
            end
            @(negedge clk);
        end
        reset = 1'b1;
        #1 vectors++;
        if ({d_last_m, d_last_l, in_ready_m, in_ready_l} !== 4'b0000) begin
            errors++; $display("FAIL rstmid_assert last/ready=%b exp=0000", {d_last_m, d_last_l, in_ready_m, in_ready_l});
        end
        @(negedge clk);
        #1 vectors++;
        if (obs !== 10'b0) begin
            errors++; $display("FAIL rstmid_after obs=%b exp=%b", obs, 10'b0);
        end
        reset = 1'b0;
        #1 vectors++;
        if (obs !== 10'b00_00_00_00_11) begin
            errors++; $display("FAIL rstmid_release obs=%b exp=%b", obs, 10'b00_00_00_00_11);
        end
        @(negedge clk);
        run_word(8'h81, "81");
    endtask

    initial begin
        test_reset();
        test_msb_lsb();
        test_back_to_back();
        test_hold();
        test_hold_last();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
